mac_operand_streamer: RTL and testbench
=======================================

MAC_OPERAND_STREAMER -- requirements
Module: mac_operand_streamer

Interface
REQ-001 Parameter int_in_lp, default 1, integer bits of each operand.
REQ-002 Parameter frac_in_lp, default 11, fractional bits of each operand.
REQ-003 Parameter depth_p, default 16, maximum vector length in pairs; power of two, >= 2.
REQ-004 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 load_valid_i  input  1  load beat present.
REQ-007 load_ready_o  output  1  streamer accepts a load beat.
REQ-008 load_a_i  input  int_in_lp+frac_in_lp  operand A, signed fixed point, range [int_in_lp-1 : -frac_in_lp].
REQ-009 load_b_i  input  int_in_lp+frac_in_lp  operand B, same format as A.
REQ-010 load_last_i  input  1  marks the final pair of a vector.
REQ-011 valid_o  output  1  pair presented to the MAC.
REQ-012 ready_i  input  1  MAC accepts the pair.
REQ-013 a_o  output  int_in_lp+frac_in_lp  operand A to the MAC.
REQ-014 b_o  output  int_in_lp+frac_in_lp  operand B to the MAC.
REQ-015 last_o  output  1  high with the final pair of the vector.
REQ-016 acc_clear_o  output  1  one-cycle pulse that clears the downstream accumulator.
REQ-017 done_o  output  1  one-cycle pulse after the final pair is accepted.

Function
REQ-018 The block SHALL be a two-state FSM: LOAD and STREAM; reset state is LOAD.
REQ-019 In LOAD, load_ready_o SHALL be 1 and valid_o 0; in STREAM, load_ready_o SHALL be 0.
REQ-020 A load handshake (load_valid_i && load_ready_o) SHALL write {load_a_i, load_b_i} to buffer entry count_r and increment count_r.
REQ-021 A load handshake with load_last_i=1, or one that fills entry depth_p-1, SHALL move the FSM to STREAM on the next edge; a full buffer with load_last_i=0 treats that beat as last.
REQ-022 The transition LOAD->STREAM SHALL assert acc_clear_o for exactly the first STREAM cycle; valid_o SHALL be 0 in that cycle.
REQ-023 From the second STREAM cycle, valid_o SHALL be 1 and a_o/b_o SHALL present entry rd_idx_r, starting at 0.
REQ-024 valid_o, a_o, b_o and last_o SHALL hold stable while valid_o=1 and ready_i=0.
REQ-025 A stream handshake (valid_o && ready_i) SHALL advance rd_idx_r by 1 on the next edge, with zero bubble cycles between consecutive pairs.
REQ-026 last_o SHALL be 1 exactly when valid_o=1 and rd_idx_r == count_r-1.
REQ-027 A handshake with last_o=1 SHALL pulse done_o in the next cycle, clear count_r and rd_idx_r, and return the FSM to LOAD in that same cycle.
REQ-028 Load beats offered during STREAM SHALL be ignored: not stored and not acknowledged.
REQ-029 Vector length 1 SHALL work: one pair with last_o=1 follows the acc_clear_o cycle.
REQ-030 Operand bits SHALL pass through unmodified; the block performs no arithmetic on data.
REQ-031 A ready_i asserted while valid_o=0 SHALL have no effect.

Reset
REQ-032 reset_i=1 SHALL force, on the next edge: FSM=LOAD, count_r=0, rd_idx_r=0, valid_o=0, last_o=0, acc_clear_o=0, done_o=0, load_ready_o=1.
REQ-033 Buffer contents need not be reset; a_o/b_o are don't-care while valid_o=0.
REQ-034 A reset asserted mid-LOAD or mid-STREAM SHALL abandon the vector with no done_o pulse, and the next load SHALL start at entry 0.

Verification
REQ-035 Load 3 pairs (A,B) = (0x400,0x200), (0x7FF,0x001), (0x800,0x800) with last on the third; ready_i=1 -> acc_clear_o 1 cycle, then 3 consecutive valid_o cycles in load order, last_o on the third, done_o in the next cycle.
REQ-036 Same vector with ready_i toggled 1,0,0,1,1 -> each pair held stable across stall cycles; exactly 3 handshakes; done_o once.
REQ-037 Load depth_p=16 pairs with load_last_i=0 throughout -> load_ready_o drops after the 16th beat; 16 pairs are streamed and last_o is set on entry 15.
REQ-038 Single pair (0xFFF,0x001) with last -> acc_clear_o, one beat with last_o=1, then done_o; the next load returns to LOAD.
REQ-039 Assert reset_i after the 2nd of 4 streamed pairs -> valid_o=0 on the next cycle, no done_o; a new 2-pair load streams correctly from entry 0.
REQ-040 Drive load_valid_i=1 throughout STREAM -> load_ready_o=0, count_r unchanged, streamed data matches the original vector.

Source files
------------

// File: rtl/mac_operand_streamer.sv
// Buffers a vector of fixed-point operand pairs, then streams them to a MAC
// with an accumulator-clear pulse before the first pair and a done pulse after the last.
module mac_operand_streamer #(
    parameter int int_in_lp  = 1,
    parameter int frac_in_lp = 11,
    parameter int depth_p    = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            load_valid_i,
    output logic                            load_ready_o,
    input  logic [int_in_lp+frac_in_lp-1:0] load_a_i,
    input  logic [int_in_lp+frac_in_lp-1:0] load_b_i,
    input  logic                            load_last_i,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [int_in_lp+frac_in_lp-1:0] a_o,
    output logic [int_in_lp+frac_in_lp-1:0] b_o,
    output logic                            last_o,
    output logic                            acc_clear_o,
    output logic                            done_o
);
    localparam int width_lp  = int_in_lp + frac_in_lp;
    localparam int addr_w_lp = $clog2(depth_p);
    localparam int cnt_w_lp  = addr_w_lp + 1;

    typedef enum logic {
        LOAD,
        STREAM
    } state_e;

    state_e                  state_r, state_n;
    logic [cnt_w_lp-1:0]     count_r;
    logic [addr_w_lp-1:0]    rd_idx_r;
    logic                    clear_pending_r;
    logic                    done_r;
    logic [2*width_lp-1:0]   buf_r [depth_p];
    logic                    load_hs;
    logic                    stream_hs;
    logic                    load_final;
    logic                    last_entry;

    // A full buffer forces the beat to be treated as the final one.
    assign load_final = load_last_i || (count_r == cnt_w_lp'(depth_p - 1));
    assign last_entry = ({1'b0, rd_idx_r} == (count_r - cnt_w_lp'(1)));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n      = state_r;
        load_ready_o = 1'b0;
        valid_o      = 1'b0;
        last_o       = 1'b0;
        acc_clear_o  = 1'b0;
        load_hs      = 1'b0;
        stream_hs    = 1'b0;
        case (state_r)
            LOAD: begin
                load_ready_o = 1'b1;
                load_hs      = load_valid_i;
                if (load_hs && load_final) begin
                    state_n = STREAM;
                end
            end
            STREAM: begin
                // The first STREAM cycle only clears the accumulator.
                acc_clear_o = clear_pending_r;
                valid_o     = !clear_pending_r;
                last_o      = !clear_pending_r && last_entry;
                stream_hs   = !clear_pending_r && ready_i;
                if (stream_hs && last_entry) begin
                    state_n = LOAD;
                end
            end
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r         <= '0;
            rd_idx_r        <= '0;
            clear_pending_r <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            clear_pending_r <= load_hs && load_final;
            done_r          <= stream_hs && last_o;
            if (load_hs) begin
                count_r <= count_r + cnt_w_lp'(1);
            end
            if (stream_hs) begin
                if (last_o) begin
                    count_r  <= '0;
                    rd_idx_r <= '0;
                end else begin
                    rd_idx_r <= rd_idx_r + addr_w_lp'(1);
                end
            end
        end
    end

    // Operand storage carries no reset; contents are only read after being written.
    always_ff @(posedge clk_i) begin
        if (load_hs) begin
            buf_r[count_r[addr_w_lp-1:0]] <= {load_a_i, load_b_i};
        end
    end

    assign a_o    = buf_r[rd_idx_r][2*width_lp-1:width_lp];
    assign b_o    = buf_r[rd_idx_r][width_lp-1:0];
    assign done_o = done_r;

endmodule

// File: tb/tb_mac_operand_streamer.sv
// Scoreboard bench for mac_operand_streamer: the driver queues expected pairs
// as they are loaded, a negedge monitor checks every streamed beat and pulse.
module tb_mac_operand_streamer;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        load_valid_i;
    logic        load_ready_o;
    logic [11:0] load_a_i;
    logic [11:0] load_b_i;
    logic        load_last_i;
    logic        valid_o;
    logic        ready_i;
    logic [11:0] a_o;
    logic [11:0] b_o;
    logic        last_o;
    logic        acc_clear_o;
    logic        done_o;

    int errors = 0;
    int checks = 0;
    int doneSeen = 0;
    int clearSeen = 0;
    int doneExpected = 0;
    int clearExpected = 0;
    logic [24:0] expQ[$];

    mac_operand_streamer dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
        .load_a_i(load_a_i), .load_b_i(load_b_i), .load_last_i(load_last_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .a_o(a_o), .b_o(b_o), .last_o(last_o),
        .acc_clear_o(acc_clear_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: protocol flags from the previous cycle predict this cycle's outputs.
    logic        prevStall = 1'b0;
    logic        prevHsMid = 1'b0;
    logic        prevHsLast = 1'b0;
    logic        prevLoadFinal = 1'b0;
    logic [24:0] heldOut = '0;
    int          monLoadCnt = 0;

    always @(negedge clk_i) begin
        if (reset_i) begin
            prevStall = 1'b0;
            prevHsMid = 1'b0;
            prevHsLast = 1'b0;
            prevLoadFinal = 1'b0;
            monLoadCnt = 0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_valid", 32'(valid_o), 32'd1);
                checkOutput("stall_hold", 32'({a_o, b_o, last_o}), 32'(heldOut));
            end
            if (prevHsMid) checkOutput("no_bubble", 32'(valid_o), 32'd1);
            if (prevHsLast) begin
                checkOutput("done_pulse", 32'(done_o), 32'd1);
                checkOutput("done_to_load", 32'(load_ready_o), 32'd1);
                checkOutput("done_no_valid", 32'(valid_o), 32'd0);
            end else if (done_o) begin
                checkOutput("done_spurious", 32'(done_o), 32'd0);
            end
            if (prevLoadFinal) begin
                checkOutput("acc_clear", 32'(acc_clear_o), 32'd1);
                checkOutput("clear_no_valid", 32'(valid_o), 32'd0);
                checkOutput("clear_no_load_ready", 32'(load_ready_o), 32'd0);
            end else if (acc_clear_o) begin
                checkOutput("acc_clear_spurious", 32'(acc_clear_o), 32'd0);
            end
            if (done_o) doneSeen++;
            if (acc_clear_o) clearSeen++;

            prevStall  = valid_o && !ready_i;
            heldOut    = {a_o, b_o, last_o};
            prevHsMid  = valid_o && ready_i && !last_o;
            prevHsLast = valid_o && ready_i && last_o;
            if (valid_o && ready_i) begin
                if (expQ.size() == 0) checkOutput("unexpected_beat", 32'd1, 32'd0);
                else checkOutput("beat", 32'({a_o, b_o, last_o}), 32'(expQ.pop_front()));
            end
            if (load_valid_i && load_ready_o) begin
                prevLoadFinal = load_last_i || (monLoadCnt == 15);
                monLoadCnt = prevLoadFinal ? 0 : monLoadCnt + 1;
            end else begin
                prevLoadFinal = 1'b0;
            end
        end
    end

    // Loads n pairs; returns #1 after the edge that accepted the final pair.
    task automatic applyStimulus(input logic [11:0] av[16], input logic [11:0] bv[16],
                                 input int n, input bit markLast);
        for (int i = 0; i < n; i++) begin
            int waited = 0;
            bit accepted = 1'b0;
            load_valid_i = 1'b1;
            load_a_i     = av[i];
            load_b_i     = bv[i];
            load_last_i  = markLast && (i == n - 1);
            while (!accepted && waited < 50) begin
                @(negedge clk_i);
                accepted = load_ready_o;
                @(posedge clk_i);
                #1;
                waited++;
            end
            if (!accepted) begin
                checkOutput("load_timeout", 32'd0, 32'd1);
                break;
            end
            expQ.push_back({av[i], bv[i], (i == n - 1)});
        end
        load_valid_i = 1'b0;
        load_last_i  = 1'b0;
    endtask

    // Drives ready_i from pat (LSB first, then 1) until done_o is seen.
    task automatic runStream(input logic [7:0] pat, input int len, input bit holdLoad);
        int startDone = doneSeen;
        int waited = 0;
        bit lastGone = 1'b0;
        if (holdLoad) begin
            load_a_i    = 12'h5A5;
            load_b_i    = 12'hA5A;
            load_last_i = 1'b0;
        end
        while (doneSeen == startDone && waited < 200) begin
            ready_i = (waited < len) ? pat[waited] : 1'b1;
            if (holdLoad && !lastGone) load_valid_i = 1'b1;
            @(negedge clk_i);
            if (holdLoad && !lastGone) checkOutput("stream_load_ready", 32'(load_ready_o), 32'd0);
            if (valid_o && ready_i && last_o) begin
                lastGone = 1'b1;
                load_valid_i = 1'b0;
            end
            @(posedge clk_i);
            #1;
            waited++;
        end
        ready_i = 1'b0;
        load_valid_i = 1'b0;
        if (doneSeen == startDone) checkOutput("done_timeout", 32'd0, 32'd1);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        doneExpected++;
        clearExpected++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [11:0] av[16];
        logic [11:0] bv[16];
        int hs;
        int waited;

        reset_i = 1'b1;
        load_valid_i = 1'b0;
        load_a_i = '0;
        load_b_i = '0;
        load_last_i = 1'b0;
        ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            av[i] = '0;
            bv[i] = '0;
        end
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        checkOutput("reset_load_ready", 32'(load_ready_o), 32'd1);
        checkOutput("reset_valid", 32'(valid_o), 32'd0);
        checkOutput("reset_last", 32'(last_o), 32'd0);
        checkOutput("reset_acc_clear", 32'(acc_clear_o), 32'd0);
        checkOutput("reset_done", 32'(done_o), 32'd0);
        @(posedge clk_i);
        #1;

        $display("[TB] basic 3-pair vector, ready always high");
        av[0] = 12'h400; bv[0] = 12'h200;
        av[1] = 12'h7FF; bv[1] = 12'h001;
        av[2] = 12'h800; bv[2] = 12'h800;
        applyStimulus(av, bv, 3, 1'b1);
        runStream(8'hFF, 8, 1'b0);

        $display("[TB] same vector with ready pattern 1,1,0,0,1,1");
        applyStimulus(av, bv, 3, 1'b1);
        runStream(8'b0011_0011, 6, 1'b0);

        $display("[TB] full 16-pair buffer without load_last");
        for (int i = 0; i < 16; i++) begin
            av[i] = 12'(12'h0A0 + i);
            bv[i] = 12'(12'hF00 - 3 * i);
        end
        applyStimulus(av, bv, 16, 1'b0);
        @(negedge clk_i);
        checkOutput("full_load_ready_drop", 32'(load_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        runStream(8'hFF, 8, 1'b0);

        $display("[TB] single pair vector");
        av[0] = 12'hFFF; bv[0] = 12'h001;
        applyStimulus(av, bv, 1, 1'b1);
        runStream(8'hFF, 8, 1'b0);

        $display("[TB] reset after second of four streamed pairs");
        av[0] = 12'h111; bv[0] = 12'h222;
        av[1] = 12'h333; bv[1] = 12'h444;
        av[2] = 12'h555; bv[2] = 12'h666;
        av[3] = 12'h777; bv[3] = 12'h888;
        applyStimulus(av, bv, 4, 1'b1);
        ready_i = 1'b1;
        hs = 0;
        waited = 0;
        while (hs < 2 && waited < 20) begin
            @(negedge clk_i);
            if (valid_o && ready_i) hs++;
            @(posedge clk_i);
            #1;
            waited++;
        end
        checkOutput("pre_reset_handshakes", 32'(hs), 32'd2);
        reset_i = 1'b1;
        ready_i = 1'b0;
        expQ.delete();
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        clearExpected++;
        @(negedge clk_i);
        checkOutput("midreset_valid", 32'(valid_o), 32'd0);
        checkOutput("midreset_load_ready", 32'(load_ready_o), 32'd1);
        checkOutput("midreset_done", 32'(done_o), 32'd0);
        checkOutput("midreset_acc_clear", 32'(acc_clear_o), 32'd0);
        @(posedge clk_i);
        #1;
        av[0] = 12'h123; bv[0] = 12'h456;
        av[1] = 12'hABC; bv[1] = 12'h0F0;
        applyStimulus(av, bv, 2, 1'b1);
        runStream(8'hFF, 8, 1'b0);

        $display("[TB] load beats offered throughout STREAM");
        av[0] = 12'h400; bv[0] = 12'h200;
        av[1] = 12'h7FF; bv[1] = 12'h001;
        av[2] = 12'h800; bv[2] = 12'h800;
        applyStimulus(av, bv, 3, 1'b1);
        runStream(8'hFF, 8, 1'b1);

        repeat (4) @(posedge clk_i);
        #1;
        checkOutput("done_total", 32'(doneSeen), 32'(doneExpected));
        checkOutput("clear_total", 32'(clearSeen), 32'(clearExpected));
        checkOutput("queue_empty_end", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
